// File: rtl/arb8_sched_pkg.sv
// arb8_sched_pkg: shared arbiter state encoding and requester count
package arb8_sched_pkg;
  localparam int NREQ = 8;
  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
endpackage

// File: rtl/arb8_sched_en_decode3_8.sv
// en_decode3_8: 3-to-8 one-hot decoder with enable
module en_decode3_8 (
  input  logic [2:0] in,
  input  logic       enable,
  output logic [7:0] out
);
  assign out = enable ? 8'(8'd1 << in) : 8'h00;
endmodule

// File: rtl/arb8_sched.sv
// arb8_sched: 8-way round-robin arbiter with hold limit and forced-release timeout
module arb8_sched
  import arb8_sched_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] grant_idx,
  output logic       grant_en,
  output logic [7:0] grant,
  output logic       timeout
);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  state_t     state, state_n;
  logic [2:0] ptr, ptr_n, idx_n, win, cand;
  logic [7:0] hold_cnt, cnt_n;
  logic       en_n, to_n, found, at_limit, rel;
  always_comb begin
    found = 1'b0;
    win   = ptr;
    cand  = ptr;
    // scan highest offset first so the nearest request at or after ptr wins
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = ptr + 3'(i);
      if (req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end
  assign at_limit = hold_cnt == HOLD_LAST;
  assign rel      = done || !req[grant_idx] || at_limit;
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = hold_cnt;
    idx_n   = grant_idx;
    en_n    = grant_en;
    to_n    = 1'b0;
    case (state)
      IDLE: if (found) begin
        idx_n   = win;
        en_n    = 1'b1;
        cnt_n   = 8'd0;
        state_n = BUSY;
      end
      BUSY: if (rel) begin
        en_n    = 1'b0;
        ptr_n   = grant_idx + 3'd1;
        state_n = RELEASE;
        to_n    = at_limit && !done && req[grant_idx];
      end else begin
        cnt_n = at_limit ? hold_cnt : hold_cnt + 8'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      hold_cnt  <= 8'd0;
      grant_idx <= 3'd0;
      grant_en  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      hold_cnt  <= cnt_n;
      grant_idx <= idx_n;
      grant_en  <= en_n;
      timeout   <= to_n;
    end
  end
  en_decode3_8 u_dec (
    .in    (grant_idx),
    .enable(grant_en),
    .out   (grant)
  );
endmodule

// File: tb/tb_arb8_sched.sv
// tb_arb8_sched: directed and random stimulus against a behavioural arbiter model
module tb_arb8_sched;
  import arb8_sched_pkg::*;
  localparam int MH = 16;
  logic       clk = 1'b0, reset = 1'b0, done = 1'b0;
  logic [7:0] req = 8'h00;
  logic [2:0] grant_idx;
  logic       grant_en, timeout;
  logic [7:0] grant;
  int vectors = 0, miscompares = 0;
  int m_mode = 0, m_owner = 0, m_ptr = 0, m_cnt = 0;
  bit m_to = 1'b0;
  always #5 clk = ~clk;
  arb8_sched #(.MAX_HOLD(MH)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .done     (done),
    .grant_idx(grant_idx),
    .grant_en (grant_en),
    .grant    (grant),
    .timeout  (timeout)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  // mode: 0 idle, 1 granted, 2 bubble after release
  task automatic model(input bit rs, input bit [7:0] r, input bit d);
    int w;
    if (!rs) begin
      m_mode = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (m_mode == 0) begin
        w = -1;
        for (int k = 0; k < 8; k++)
          if (w < 0 && r[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
        if (w >= 0) begin
          m_owner = w; m_mode = 1; m_cnt = 0;
        end
      end else if (m_mode == 1) begin
        if (d || !r[m_owner] || m_cnt == MH - 1) begin
          m_to   = !d && r[m_owner] && m_cnt == MH - 1;
          m_ptr  = (m_owner + 1) % 8;
          m_mode = 2;
        end else m_cnt++;
      end else m_mode = 0;
    end
  endtask
  task automatic step(input bit rs, input bit [7:0] r, input bit d, input string tag);
    state_t es;
    reset = rs; req = r; done = d;
    @(posedge clk);
    model(rs, r, d);
    #1;
    es = m_mode == 0 ? IDLE : m_mode == 1 ? BUSY : RELEASE;
    chk({tag, " grant_en"}, 8'(grant_en), 8'(m_mode == 1));
    chk({tag, " grant_idx"}, 8'(grant_idx), 8'(m_owner));
    chk({tag, " grant"}, grant, m_mode == 1 ? 8'(1 << m_owner) : 8'h00);
    chk({tag, " timeout"}, 8'(timeout), 8'(m_to));
    chk({tag, " ptr"}, 8'(dut.ptr), 8'(m_ptr));
    chk({tag, " state"}, 8'(dut.state), 8'(es));
  endtask
  initial begin
    step(0, 8'h00, 0, "reset");
    step(0, 8'h00, 0, "reset");
    step(1, 8'h00, 0, "idle");
    step(1, 8'h00, 1, "idle_done");
    repeat (4) begin
      step(1, 8'h81, 0, "rr_grant");
      step(1, 8'h81, 0, "rr_hold");
      step(1, 8'h81, 1, "rr_done");
      step(1, 8'h81, 0, "rr_bubble");
    end
    step(0, 8'h00, 0, "reset");
    repeat (20) step(1, 8'h04, 0, "hold_limit");
    step(0, 8'h00, 0, "reset");
    step(1, 8'h04, 0, "lim_grant");
    repeat (15) step(1, 8'h04, 0, "lim_hold");
    step(1, 8'h04, 1, "done_at_limit");
    step(1, 8'h04, 0, "lim_bubble");
    step(0, 8'h00, 0, "reset");
    step(1, 8'h20, 0, "own5_grant");
    step(1, 8'h21, 0, "own5_hold");
    step(1, 8'h01, 0, "own5_drop");
    step(1, 8'h21, 0, "own5_bubble");
    step(1, 8'h21, 0, "wrap_idle");
    step(1, 8'h21, 0, "wrap_grant0");
    step(0, 8'h00, 0, "reset");
    step(1, 8'h08, 0, "own3_grant");
    step(1, 8'hff, 0, "own3_hold");
    step(1, 8'hff, 0, "own3_hold");
    step(0, 8'hff, 0, "reset_busy");
    step(1, 8'hff, 0, "after_reset");
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) != 0,
           $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom),
           $urandom_range(0, 3) == 0, "rand");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
